// File: rtl/ks_sched_pkg.sv
// Shared types and constants for the two-requester Kogge-Stone adder scheduler.
package ks_sched_pkg;

    localparam int NREQ      = 2;
    localparam int DEFAULT_W = 16;

    typedef logic req_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/ks_sum_inc_core.sv
// Combinational Kogge-Stone adder producing a+b and a+b+1 from one prefix tree; ci picks the result.
module ks_sum_inc_core
    import ks_sched_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W-1:0] h;
    logic [W-1:0] gk, pk;
    logic [W-1:0] gn, pn;
    logic [W-1:0] sum0, sum1;

    always_comb begin
        h  = a ^ b;
        gk = a & b;
        pk = a ^ b;
        gn = gk;
        pn = pk;
        // Each level: black cells combine (g,p) with the span d below; low bits pass through (white).
        for (int d = 1; d < W; d = d * 2) begin
            gn = gk;
            pn = pk;
            for (int i = d; i < W; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i-d]);
                pn[i] = pk[i] & pk[i-d];
            end
            gk = gn;
            pk = pn;
        end
        // Carry into bit i is the group generate (ci=0) or group generate|propagate (ci=1) of bits below.
        sum0 = h ^ {gk[W-2:0], 1'b0};
        sum1 = h ^ {gk[W-2:0] | pk[W-2:0], 1'b1};
        sum  = ci ? sum1 : sum0;
        cout = ci ? (gk[W-1] | pk[W-1]) : gk[W-1];
    end

endmodule

// File: rtl/ks_add_sched.sv
// Round-robin scheduler sharing one adder core between two multi-beat requesters, with a registered response.
//  state | meaning
//  IDLE  | no transaction open; arbitrate among valid requesters
//  LOCK  | owner mid-transaction; only owner served, carry chained from carry_q
module ks_add_sched
    import ks_sched_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_cin,
    input  logic [NREQ-1:0]     req_last,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_cout,
    output logic                rsp_last
);

    state_t       state_q, state_d;
    req_id_t      last_gnt_q, owner_q, gnt;
    logic         carry_q;
    logic         out_free, accept, ci;
    logic [W-1:0] a_sel, b_sel, sum_w;
    logic         cout_w;

    ks_sum_inc_core #(.W(W)) u_core (
        .a    (a_sel),
        .b    (b_sel),
        .ci   (ci),
        .sum  (sum_w),
        .cout (cout_w)
    );

    always_comb begin
        out_free = !rsp_valid || rsp_ready;
        gnt      = owner_q;
        if (state_q == IDLE) begin
            gnt = (&req_valid) ? ~last_gnt_q : req_valid[1];
        end
        req_ready = '0;
        if (rst_n && out_free && ((state_q == LOCK) || (|req_valid))) begin
            req_ready[gnt] = 1'b1;
        end
        accept  = req_valid[gnt] && req_ready[gnt];
        ci      = (state_q == IDLE) ? req_cin[gnt] : carry_q;
        a_sel   = gnt ? req_a[2*W-1:W] : req_a[W-1:0];
        b_sel   = gnt ? req_b[2*W-1:W] : req_b[W-1:0];
        state_d = state_q;
        if (accept) begin
            state_d = req_last[gnt] ? IDLE : LOCK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            carry_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_last   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                carry_q <= cout_w;
                if (req_last[gnt]) begin
                    last_gnt_q <= gnt;
                end else begin
                    owner_q <= gnt;
                end
                rsp_valid <= 1'b1;
                rsp_id    <= gnt;
                rsp_sum   <= sum_w;
                rsp_cout  <= cout_w;
                rsp_last  <= req_last[gnt];
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ks_add_sched.sv
// Randomized and directed bench for ks_add_sched (W=8) against a queue-based reference model.
module tb_ks_add_sched;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a, req_b;
    logic [1:0]     req_cin, req_last;
    logic           rsp_valid, rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout, rsp_last;

    ks_add_sched #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_last  (rsp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       id;
        bit [7:0] sum;
        bit       cout;
        bit       last;
    } rsp_t;

    rsp_t exp_q[$];
    int   owner_m = -1;
    bit   last_m  = 1'b1;
    bit   carry_m = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: outstanding response words in a queue, transaction ownership as an integer.
    always @(negedge clk) begin
        rsp_t       e;
        int         g;
        bit         free_m, acc;
        bit         ci_m;
        logic [1:0] exp_ready;
        logic [8:0] full;
        if (!rst_n) begin
            chk("ready_in_reset", {30'd0, req_ready}, 32'd0);
            exp_q.delete();
            owner_m = -1;
            last_m  = 1'b1;
            carry_m = 1'b0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_id",    {31'd0, rsp_id},    {31'd0, e.id});
                chk("rsp_sum",   {24'd0, rsp_sum},   {24'd0, e.sum});
                chk("rsp_cout",  {31'd0, rsp_cout},  {31'd0, e.cout});
                chk("rsp_last",  {31'd0, rsp_last},  {31'd0, e.last});
            end else begin
                chk("rsp_idle", {31'd0, rsp_valid}, 32'd0);
            end
            free_m = (exp_q.size() == 0) || rsp_ready;
            if (owner_m >= 0) g = owner_m;
            else if (req_valid == 2'b11) g = last_m ? 0 : 1;
            else g = req_valid[1] ? 1 : 0;
            exp_ready = 2'b00;
            if (free_m && (owner_m >= 0 || req_valid != 2'b00)) exp_ready[g] = 1'b1;
            if (owner_m >= 0 || req_valid != 2'b00)
                chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
            acc = free_m && req_valid[g];
            if (exp_q.size() > 0 && rsp_ready) void'(exp_q.pop_front());
            if (acc) begin
                ci_m = (owner_m < 0) ? req_cin[g] : carry_m;
                full = 9'(req_a[g*W +: W]) + 9'(req_b[g*W +: W]) + 9'(ci_m);
                e.id   = g[0];
                e.sum  = full[7:0];
                e.cout = full[8];
                e.last = req_last[g];
                exp_q.push_back(e);
                if (req_last[g]) begin
                    owner_m = -1;
                    last_m  = g[0];
                end else begin
                    owner_m = g;
                    carry_m = full[8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = 2'b00;
        req_last  = 2'b00;
        req_cin   = 2'b00;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic last);
        req_valid[i]   = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]     = cin;
        req_last[i]    = last;
    endtask

    initial begin
        idle_in();
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_id",    {31'd0, rsp_id},    32'd0);
        chk("reset_rsp_sum",   {24'd0, rsp_sum},   32'd0);
        chk("reset_rsp_cout",  {31'd0, rsp_cout},  32'd0);
        chk("reset_rsp_last",  {31'd0, rsp_last},  32'd0);
        step();
        rst_n = 1'b1;

        // single beat 7F+01
        set_req(0, 8'h7F, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_ready", {30'd0, req_ready}, 32'd1);
        step();
        idle_in();
        @(negedge clk);
        chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_sum",   {24'd0, rsp_sum},   32'h80);
        chk("t1_cout",  {31'd0, rsp_cout},  32'd0);
        chk("t1_last",  {31'd0, rsp_last},  32'd1);
        step();

        // two-beat on req1, carry chained
        set_req(1, 8'hFF, 8'h01, 1'b0, 1'b0);
        step();
        set_req(1, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_b0_sum",  {24'd0, rsp_sum},  32'h00);
        chk("t2_b0_cout", {31'd0, rsp_cout}, 32'd1);
        chk("t2_b0_id",   {31'd0, rsp_id},   32'd1);
        step();
        idle_in();
        @(negedge clk);
        chk("t2_b1_sum",  {24'd0, rsp_sum},  32'h01);
        chk("t2_b1_cout", {31'd0, rsp_cout}, 32'd0);
        chk("t2_b1_last", {31'd0, rsp_last}, 32'd1);
        step();

        // alternating grants after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 8'h01, 8'h10, 1'b0, 1'b1);
        set_req(1, 8'h20, 8'h02, 1'b0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            step();
            @(negedge clk);
            chk("t3_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_id",    {31'd0, rsp_id},    32'(r % 2));
            chk("t3_sum",   {24'd0, rsp_sum},   (r % 2 == 0) ? 32'h11 : 32'h22);
        end
        idle_in();
        step();

        // req0 two-beat with a gap while req1 waits
        set_req(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        step();
        req_valid[0] = 1'b0;
        set_req(1, 8'h33, 8'h44, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_gap_req1_ready", {31'd0, req_ready[1]}, 32'd0);
        step();
        set_req(0, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_b1_ready", {30'd0, req_ready}, 32'd1);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t4_b1_sum",  {24'd0, rsp_sum},  32'h01);
        chk("t4_b1_id",   {31'd0, rsp_id},   32'd0);
        chk("t4_req1_gnt", {30'd0, req_ready}, 32'd2);
        step();
        idle_in();
        @(negedge clk);
        chk("t4_req1_sum", {24'd0, rsp_sum}, 32'h77);
        chk("t4_req1_id",  {31'd0, rsp_id},  32'd1);
        step();

        // output stall
        set_req(0, 8'h10, 8'h20, 1'b0, 1'b1);
        step();
        rsp_ready = 1'b0;
        set_req(0, 8'h05, 8'h06, 1'b0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("t5_stall_ready", {30'd0, req_ready}, 32'd0);
            chk("t5_stall_sum",   {24'd0, rsp_sum},   32'h30);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t5_release_ready", {30'd0, req_ready}, 32'd1);
        step();
        idle_in();
        @(negedge clk);
        chk("t5_next_sum", {24'd0, rsp_sum}, 32'h0B);
        step();

        // reset mid-transaction
        set_req(0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        step();
        idle_in();
        @(negedge clk);
        chk("t6_b0_sum",  {24'd0, rsp_sum},  32'hFF);
        chk("t6_b0_cout", {31'd0, rsp_cout}, 32'd1);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("t6_reset_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        set_req(0, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        idle_in();
        @(negedge clk);
        chk("t6_fresh_sum",  {24'd0, rsp_sum},  32'h00);
        chk("t6_fresh_cout", {31'd0, rsp_cout}, 32'd0);
        step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i]    = ($urandom_range(0, 3) != 0);
                req_a[i*W +: W] = 8'($urandom());
                req_b[i*W +: W] = 8'($urandom());
                req_cin[i]      = 1'($urandom());
                req_last[i]     = ($urandom_range(0, 2) == 0);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            step();
        end
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        idle_in();
        step();
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
